// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: one-hot ALU function encoding,
// the request record carried through the issue stage, and a one-hot helper.
package alu_share_arbiter_pkg;

   localparam int ALU_FUN_W = 11;
   localparam int ALU_TAG_W = 4;

   typedef logic [ALU_FUN_W-1:0] alu_fun_t;

   localparam alu_fun_t ALU_FUN_ADD   = 11'b000_0000_0001;
   localparam alu_fun_t ALU_FUN_SUB   = 11'b000_0000_0010;
   localparam alu_fun_t ALU_FUN_SLL   = 11'b000_0000_0100;
   localparam alu_fun_t ALU_FUN_SLT   = 11'b000_0000_1000;
   localparam alu_fun_t ALU_FUN_SLTU  = 11'b000_0001_0000;
   localparam alu_fun_t ALU_FUN_XOR   = 11'b000_0010_0000;
   localparam alu_fun_t ALU_FUN_SRL   = 11'b000_0100_0000;
   localparam alu_fun_t ALU_FUN_SRA   = 11'b000_1000_0000;
   localparam alu_fun_t ALU_FUN_OR    = 11'b001_0000_0000;
   localparam alu_fun_t ALU_FUN_AND   = 11'b010_0000_0000;
   localparam alu_fun_t ALU_FUN_COPY1 = 11'b100_0000_0000;

   typedef struct packed {
      logic [31:0]          op1;
      logic [31:0]          op2;
      alu_fun_t             fun;
      logic                 id;
      logic [ALU_TAG_W-1:0] tag;
   } alu_req_t;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   function automatic logic fun_is_onehot(input alu_fun_t f);
      return (f != '0) && ((f & (f - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational one-hot ALU; each function bit selects one result path
// and a non-one-hot vector yields the XOR of the selected paths.
module alu
   import alu_share_arbiter_pkg::*;
(
   input  logic [31:0]          op1,
   input  logic [31:0]          op2,
   input  logic [ALU_FUN_W-1:0] fun,
   output logic [31:0]          result
);

   logic [31:0] path [ALU_FUN_W];

   always_comb begin
      path[0]  = op1 + op2;
      path[1]  = op1 - op2;
      path[2]  = op1 << op2[4:0];
      path[3]  = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
      path[4]  = (op1 < op2) ? 32'd1 : 32'd0;
      path[5]  = op1 ^ op2;
      path[6]  = op1 >> op2[4:0];
      path[7]  = $signed(op1) >>> op2[4:0];
      path[8]  = op1 | op2;
      path[9]  = op1 & op2;
      path[10] = op1;
      result = '0;
      for (int i = 0; i < ALU_FUN_W; i++) begin
         result = result ^ (path[i] & {32{fun[i]}});
      end
   end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant; the priority pointer flips to the other port
// whenever a granted request is actually accepted.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_valid,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   logic prio;

   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = prio ? 2'b10 : 2'b01;
         default: o_grant = 2'b00;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prio <= 1'b0;
      end else if (i_accept) begin
         prio <= o_grant[0];
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter feeding one shared ALU through an issue and a result stage.
// Define ALU_SHARE_ONEHOT_CHK_EN to flag non-one-hot functions (result forced to 0, o_err set).
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int TAG_W = ALU_TAG_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_req_valid,
   output logic [1:0]       o_req_ready,
   input  logic [31:0]      i_op1_0,
   input  logic [31:0]      i_op2_0,
   input  logic [31:0]      i_op1_1,
   input  logic [31:0]      i_op2_1,
   input  logic [10:0]      i_fun_0,
   input  logic [10:0]      i_fun_1,
   input  logic [TAG_W-1:0] i_tag_0,
   input  logic [TAG_W-1:0] i_tag_1,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [31:0]      o_result,
   output logic             o_res_id,
   output logic [TAG_W-1:0] o_res_tag,
   output logic             o_err
);

   alu_req_t             s1_req;
   logic                 s1_valid;
   logic                 s2_valid;
   logic [31:0]          s2_result;
   logic                 s2_id;
   logic [ALU_TAG_W-1:0] s2_tag;
   logic                 s1_adv;
   logic                 s2_adv;
   logic [1:0]           grant;
   logic                 accept;
   alu_req_t             in_req;
   logic [31:0]          alu_out;
   logic [31:0]          s2_next_result;

   assign s2_adv      = !s2_valid || i_res_ready;
   assign s1_adv      = !s1_valid || s2_adv;
   assign o_req_ready = i_rst ? 2'b00 : (grant & {2{s1_adv}});
   assign accept      = |(i_req_valid & o_req_ready);

   rr_arb2 u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_req_valid),
      .i_accept (accept),
      .o_grant  (grant)
   );

   always_comb begin
      in_req = '0;
      if (grant[1]) begin
         in_req.op1 = i_op1_1;
         in_req.op2 = i_op2_1;
         in_req.fun = i_fun_1;
         in_req.id  = 1'b1;
         in_req.tag = ALU_TAG_W'(i_tag_1);
      end else begin
         in_req.op1 = i_op1_0;
         in_req.op2 = i_op2_0;
         in_req.fun = i_fun_0;
         in_req.id  = 1'b0;
         in_req.tag = ALU_TAG_W'(i_tag_0);
      end
   end

   // Issue stage: an empty or draining slot either takes the accepted request or empties.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
      end else if (s1_adv) begin
         s1_valid <= accept;
         if (accept) begin
            s1_req <= in_req;
         end
      end
   end

   alu u_alu (
      .op1    (s1_req.op1),
      .op2    (s1_req.op2),
      .fun    (s1_req.fun),
      .result (alu_out)
   );

`ifdef ALU_SHARE_ONEHOT_CHK_EN
   logic s1_err;
   logic s2_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_err <= 1'b0;
      end else if (s1_adv && accept) begin
         s1_err <= !fun_is_onehot(in_req.fun);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_err <= 1'b0;
      end else if (s2_adv && s1_valid) begin
         s2_err <= s1_err;
      end
   end

   assign s2_next_result = s1_err ? 32'd0 : alu_out;
   assign o_err          = s2_err;
`else
   assign s2_next_result = alu_out;
   assign o_err          = 1'b0;
`endif

   // Result stage holds its contents while the consumer stalls, keeping outputs stable.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_id     <= 1'b0;
         s2_tag    <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= s2_next_result;
            s2_id     <= s1_req.id;
            s2_tag    <= s1_req.tag;
         end
      end
   end

   assign o_res_valid = s2_valid;
   assign o_result    = s2_result;
   assign o_res_id    = s2_id;
   assign o_res_tag   = TAG_W'(s2_tag);

endmodule
